lights_sequencer: RTL

LIGHTS_SEQUENCER -- requirements
Module: lights_sequencer

---
 rtl/lights_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lights_sequencer.sv
// lights_sequencer: drives a lights selector with one-cycle advance pulses.
// Pulses come from a synchronised pushbutton or from a periodic timer in AUTO
// mode. white_req forces the selector to white and cancels pending pulses.
// Optional feature: define LIGHTS_SEQUENCER_DEBOUNCE_EN to insert a debounce
// filter (DB_CYCLES stable samples) between the synchroniser and the edge
// detector; without it the synchroniser output feeds the edge detector directly.
module lights_sequencer #(
    parameter int DB_CYCLES = 4,
    parameter int PERIOD_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                manual_btn,
    input  logic                white_req,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                button,
    output logic                sel,
    output logic [2:0]          step_cnt,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_WHITE  = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10
    } state_t;

    // DB_CYCLES must fit the 4-bit debounce counter.
    if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_db_range
        $error("lights_sequencer: DB_CYCLES must be in 1..15");
    end

    // Input conditioning state
    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_vld;      // shifts in ones after reset: r_vld[1] => r_sync2 holds a real sample
    logic       r_prev;     // filtered level seen on the previous edge
    logic       r_armed;    // filtered level has been seen low since reset
    logic       w_filt;

    // FSM / pulse state
    state_t              r_state;
    logic                r_sel;
    logic                r_button;
    logic                r_defer;
    logic [PERIOD_W-1:0] r_timer;
    logic [2:0]          r_step;

    state_t w_next_state;
    logic   w_rise;
    logic   w_man_req;
    logic   w_tmr_req;
    logic   w_req;
    logic   w_issue;
    logic   w_stay_auto;

    // Two-flop synchroniser plus a validity shift so stale reset zeros are not
    // mistaken for a released button.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
        end else begin
            r_sync1 <= manual_btn;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
        end
    end

`ifdef LIGHTS_SEQUENCER_DEBOUNCE_EN
    logic [3:0] r_db_cnt;
    logic       r_filt;

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_db_cnt <= 4'd0;
            r_filt   <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= 4'd0;
        end else if (r_db_cnt == 4'(DB_CYCLES - 1)) begin
            r_db_cnt <= 4'd0;
            r_filt   <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + 4'd1;
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    // Edge-detect history and arming: a level already high at reset release
    // never looks like a press until it has been seen low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= w_filt;
            r_armed <= r_armed | (r_vld[1] & ~r_sync2 & ~w_filt);
        end
    end

    // Next-state priority and pulse request merging.
    always_comb begin
        w_next_state = ST_MANUAL;
        if (white_req) begin
            w_next_state = ST_WHITE;
        end else if (auto_en && (period != '0)) begin
            w_next_state = ST_AUTO;
        end
        w_stay_auto = (r_state == ST_AUTO) && (w_next_state == ST_AUTO);
        w_rise      = w_filt & ~r_prev & r_armed;
        w_man_req   = w_rise && (r_state != ST_WHITE);
        // Compare against the live period so a mid-count change acts at once.
        w_tmr_req   = w_stay_auto && (r_timer >= (period - PERIOD_W'(1)));
        w_req       = w_man_req | w_tmr_req | r_defer;
        // A request landing right after a pulse is held one cycle instead.
        w_issue     = w_req & ~r_button;
    end

    // FSM with registered outputs, pulse generation, timer and step counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_WHITE;
            r_sel    <= 1'b0;
            r_button <= 1'b0;
            r_defer  <= 1'b0;
            r_timer  <= '0;
            r_step   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= (w_next_state != ST_WHITE);
            if (w_next_state == ST_WHITE) begin
                r_button <= 1'b0;
                r_defer  <= 1'b0;
                r_timer  <= '0;
            end else begin
                r_button <= w_issue;
                r_defer  <= w_req & r_button;
                if (w_issue) begin
                    r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
                end
                // Timer restarts on AUTO entry/exit and on every issued pulse.
                if (w_stay_auto && !w_issue) begin
                    r_timer <= r_timer + PERIOD_W'(1);
                end else begin
                    r_timer <= '0;
                end
            end
        end
    end

    assign button   = r_button;
    assign sel      = r_sel;
    assign step_cnt = r_step;
    assign state    = r_state;

endmodule
